cordic_sincos: RTL

CORDIC_SINCOS -- requirements
Module: cordic_sincos

---
 rtl/cordic_pkg.sv | 59 +++++
 rtl/cordic_atan_rom.sv | 30 +++
 rtl/cordic_sincos.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the CORDIC sine/cosine block.
// Everything here is integer-only, so the tables are built without real-number math.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  // atan(1/n) scaled by 2^56, computed from the Taylor series.
  function automatic longint atan_inv(input longint n);
    longint p;
    longint acc;
    acc = 0;
    p = (64'sd1 <<< 56) / n;
    for (int m = 0; m < 64; m++) begin
      if (p != 0) begin
        if (m % 2 == 0) acc = acc + p / longint'(2 * m + 1);
        else            acc = acc - p / longint'(2 * m + 1);
        p = p / (n * n);
      end
    end
    return acc;
  endfunction

  // atan(2^-i) scaled by 2^56; i = 0 uses Machin's formula, because the series for 1 barely converges.
  function automatic longint atan_q56(input int i);
    if (i == 0) return 4 * atan_inv(64'sd5) - atan_inv(64'sd239);
    return atan_inv(64'sd1 <<< i);
  endfunction

  // atan(2^-i) with frac fractional bits, rounded to nearest.
  function automatic longint atan_entry(input int i, input int frac);
    return (atan_q56(i) + (64'sd1 <<< (55 - frac))) >>> (56 - frac);
  endfunction

  function automatic longint pi_q(input int frac);
    return (4 * atan_q56(0) + (64'sd1 <<< (55 - frac))) >>> (56 - frac);
  endfunction

  function automatic longint half_pi_q(input int frac);
    return (2 * atan_q56(0) + (64'sd1 <<< (55 - frac))) >>> (56 - frac);
  endfunction

  // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) for iter stages, with frac fractional bits.
  function automatic longint k_const(input int iter, input int frac);
    logic [63:0] p, r, v, s, c;
    p = 64'd1 << 30;
    for (int i = 0; i < 32; i++) begin
      if (i < iter) p = p + (p >> (2 * i));
    end
    r = (64'd1 << 60) / p;
    v = r << 30;
    s = '0;
    for (int b = 31; b >= 0; b--) begin
      c = s | (64'd1 << b);
      if (c * c <= v) s = c;
    end
    return longint'((s + (64'd1 << (29 - frac))) >> (30 - frac));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: iteration index -> atan(2^-i) in Q3.(WIDTH-3+GUARD).
// Zero latency; out-of-range indices return zero.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14,
  parameter int GUARD = 2,
  localparam int IW   = WIDTH + GUARD,
  localparam int IDXW = $clog2(ITER)
) (
  input  logic        [IDXW-1:0] idx,
  output logic signed [IW-1:0]   atan
);

  logic signed [IW-1:0] table_q [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_entry
    localparam logic signed [IW-1:0] ENT = IW'(atan_entry(g, WIDTH - 3 + GUARD));
    assign table_q[g] = ENT;
  end

  always_comb begin
    atan = '0;
    for (int k = 0; k < ITER; k++) begin
      if (idx == IDXW'(k)) atan = table_q[k];
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine: one micro-rotation per cycle, result ITER+1 cycles after start.
// start is only honoured in IDLE; the angle is clamped to +/-pi and folded into +/-pi/2.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] sin_out,
  output logic signed [WIDTH-1:0] cos_out,
  output logic                    range_err
);

  localparam int IW = WIDTH + GUARD;
  localparam int CW = $clog2(ITER);

  localparam logic signed [WIDTH-1:0] PI_A      = WIDTH'(pi_q(WIDTH - 3));
  localparam logic signed [WIDTH-1:0] HALF_PI_A = WIDTH'(half_pi_q(WIDTH - 3));
  localparam logic signed [IW-1:0]    K_I       = IW'(k_const(ITER, WIDTH - 2 + GUARD));
  localparam logic signed [IW+1:0]    ONE_T     = (IW + 2)'(1) <<< (WIDTH - 2);
  localparam logic signed [IW+1:0]    RND_T     = (GUARD > 0) ? ((IW + 2)'(1) <<< (GUARD - 1)) : '0;

  state_t               state, state_nxt;
  logic [CW-1:0]        iter_cnt;
  logic signed [IW-1:0] x, y, z;
  logic signed [IW-1:0] x_sh, y_sh, atan_i;
  logic                 neg_flag, clamp_flag;
  logic signed [WIDTH-1:0] ang_c, ang_f;
  logic                 ang_oor, ang_neg;

  cordic_atan_rom #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(GUARD)) u_rom (
    .idx  (iter_cnt),
    .atan (atan_i)
  );

  // Round half-up to the output grid, apply the fold sign, clip to [-1.0, +1.0].
  function automatic logic signed [WIDTH-1:0] sat_round(input logic signed [IW-1:0] v, input logic neg);
    logic signed [IW+1:0] t;
    t = (IW + 2)'(v) + RND_T;
    t = t >>> GUARD;
    if (neg) t = -t;
    if (t > ONE_T)       t = ONE_T;
    else if (t < -ONE_T) t = -ONE_T;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    ang_c   = angle;
    ang_oor = 1'b0;
    if (angle > PI_A) begin
      ang_c   = PI_A;
      ang_oor = 1'b1;
    end else if (angle < -PI_A) begin
      ang_c   = -PI_A;
      ang_oor = 1'b1;
    end
    ang_f   = ang_c;
    ang_neg = 1'b0;
    if (ang_c > HALF_PI_A) begin
      ang_f   = ang_c - PI_A;
      ang_neg = 1'b1;
    end else if (ang_c < -HALF_PI_A) begin
      ang_f   = ang_c + PI_A;
      ang_neg = 1'b1;
    end
  end

  always_comb begin
    x_sh = x >>> iter_cnt;
    y_sh = y >>> iter_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROTATE;
      ROTATE:  if (iter_cnt == CW'(ITER - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      neg_flag   <= 1'b0;
      clamp_flag <= 1'b0;
      done       <= 1'b0;
      sin_out    <= '0;
      cos_out    <= '0;
      range_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x          <= K_I;
            y          <= '0;
            z          <= IW'(ang_f) <<< GUARD;
            neg_flag   <= ang_neg;
            clamp_flag <= ang_oor;
            iter_cnt   <= '0;
          end
        end
        ROTATE: begin
          // Rotate toward z = 0; the sign of z picks the direction.
          if (!z[IW-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_i;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_i;
          end
          iter_cnt <= iter_cnt + 1'b1;
        end
        DONE: begin
          cos_out   <= sat_round(x, neg_flag);
          sin_out   <= sat_round(y, neg_flag);
          range_err <= clamp_flag;
          done      <= 1'b1;
          iter_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
